// File: rtl/calc_pkg.sv
// Purpose: shared constants and types for the calculator datapath blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   WIDTH / DIGITS   binary operand width and number of packed BCD digits
//   state_t          converter FSM states
//   bcd_digit_t      one packed BCD digit
//   magnitude()      unsigned magnitude of a two's-complement operand
package calc_pkg;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    // One shift per clock, WIDTH shifts per conversion.
    localparam int CNT_W = 5;
    localparam int BCD_W = 4 * DIGITS;

    // Counter value on the cycle that performs the final shift.
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    // Held as unsigned WIDTH bits, so the most negative value maps to
    // 2^(WIDTH-1) without overflow: ~0x80000000 + 1 == 0x80000000.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v[WIDTH-1]) begin
            r = (~v) + WIDTH'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage : calc_pkg

// File: rtl/bcd_add3.sv
// Purpose: double-dabble digit correction; adds 3 to a BCD digit >= 5.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   digit_i  working BCD digit before the shift
//   digit_o  corrected digit (digit_i + 3 when digit_i >= 5, else digit_i)
module bcd_add3
    import calc_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    // A digit of 5..9 becomes 8..12, so the following left shift carries
    // exactly one into the next digit and leaves a valid 0..9 behind.
    // Inputs above 9 cannot occur in a working register, so no wrap concern.
    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// Purpose: sequential signed binary-to-BCD converter (double-dabble, 1 shift/clk).
// Latency: 32 clocks from accepting edge to done; one conversion per 33 clocks.
// Backpressure: none; start is only honoured in IDLE, ignored (not queued) while busy.
//
// Ports:
//   clk_i    single clock, all state changes on posedge
//   reset_i  asynchronous active-high reset, clears all state immediately
//   start_i  conversion request, sampled only in IDLE
//   value_i  two's-complement operand, sampled on the accepting edge only
//   busy_o   high while a conversion is in progress
//   done_o   one-cycle pulse in the cycle bcd_o/neg_o have just updated
//   neg_o    sign of the last converted value (1 = negative)
//   bcd_o    packed BCD digits, digit 0 (units) in [3:0]
module bin2bcd_seq
    import calc_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     value_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 neg_o,
    output logic [BCD_W-1:0]     bcd_o
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mag_q,   mag_d;     // magnitude being shifted out MSB first
    logic [BCD_W-1:0]   work_q,  work_d;    // working BCD accumulator
    logic               sign_q,  sign_d;    // sign captured at accept
    logic [BCD_W-1:0]   bcd_q,   bcd_d;     // published result
    logic               neg_q,   neg_d;
    logic               done_q,  done_d;

    logic               accept;
    logic               last_shift;

    // Corrected digits, then the combined {work, mag} left shift.
    logic [BCD_W-1:0]   adj_work;
    logic [BCD_W-1:0]   shifted_work;
    logic [WIDTH-1:0]   shifted_mag;

    // Digit 9 never reaches 5 for a 32-bit magnitude (max 2147483648), so
    // the bit shifted out of the top of the working register is always 0.
    logic               adj_msb_unused;

    assign accept     = (state_q == IDLE) && start_i;
    assign last_shift = (state_q == CONVERT) && (count_q == LAST_SHIFT);

    // ------------------------------------------------------------------
    // Per-digit add-3 correction, applied before every shift
    // ------------------------------------------------------------------
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (work_q[4*g +: 4]),
            .digit_o (adj_work[4*g +: 4])
        );
    end

    assign shifted_work   = {adj_work[BCD_W-2:0], mag_q[WIDTH-1]};
    assign shifted_mag    = {mag_q[WIDTH-2:0], 1'b0};
    assign adj_msb_unused = adj_work[BCD_W-1];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (count_q == LAST_SHIFT) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_o = 1'b0;
        case (state_q)
            IDLE:    busy_o = 1'b0;
            CONVERT: busy_o = 1'b1;
            default: busy_o = 1'b0;
        endcase
    end

    assign done_o = done_q;
    assign neg_o  = neg_q;
    assign bcd_o  = bcd_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        mag_d   = mag_q;
        work_d  = work_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        done_d  = 1'b0;

        if (accept) begin
            mag_d   = magnitude(value_i);
            sign_d  = value_i[WIDTH-1];
            count_d = '0;
            work_d  = '0;
        end else if (state_q == CONVERT) begin
            mag_d   = shifted_mag;
            work_d  = shifted_work;
            // Wraps 31 -> 0 on the final shift, leaving the counter clear.
            count_d = count_q + CNT_W'(1);
        end

        // Publish the post-shift value directly so the result is visible in
        // the same cycle done is high, not one cycle later.
        if (last_shift) begin
            bcd_d  = shifted_work;
            neg_d  = sign_q;
            done_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            mag_q   <= '0;
            work_q  <= '0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            mag_q   <= mag_d;
            work_q  <= work_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
        end
    end

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// Purpose: randomized scoreboard bench for bin2bcd_seq.
// Latency: expects done exactly 32 clocks after each accepting edge.
// Backpressure: drives start only when the converter is expected idle, plus deliberate ignored/held starts.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        neg;
    logic [39:0] bcd;

    bin2bcd_seq dut (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (start),
        .value_i (value),
        .busy_o  (busy),
        .done_o  (done),
        .neg_o   (neg),
        .bcd_o   (bcd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [39:0] bcd;
        logic        neg;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [39:0] last_bcd = '0;
    logic        last_neg = 1'b0;

    // Reference: absolute value in wide arithmetic, then decimal digits by
    // repeated division.
    function automatic void ref_conv(input logic [31:0] v,
                                     output logic [39:0] b,
                                     output logic n);
        longint unsigned m;
        n = v[31];
        m = v[31] ? (64'd4294967296 - 64'(v)) : 64'(v);
        b = '0;
        for (int i = 0; i < 10; i++) begin
            b[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called at #1 after the accepting edge.
    task automatic push(input logic [31:0] v);
        exp_t e;
        ref_conv(v, e.bcd, e.neg);
        e.cyc = cyc + 32;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] v);
        @(posedge clk);
        #1;
        start = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        push(v);
        start = 1'b0;
        value = $urandom;   // operand changes mid-conversion must be ignored
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    always @(negedge clk) begin
        if (!reset) begin
            check("busy_done_excl", 64'(busy & done), 64'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done bcd=%0h want no done (cycle %0d)", bcd, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_bcd", 64'(bcd), 64'(e.bcd));
                    check("result_neg", 64'(neg), 64'(e.neg));
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    last_bcd = e.bcd;
                    last_neg = e.neg;
                end
            end else begin
                check("hold_bcd", 64'(bcd), 64'(last_bcd));
                check("hold_neg", 64'(neg), 64'(last_neg));
            end
        end
    end

    initial begin
        logic [31:0] dir [6];
        logic [31:0] v;
        dir = '{32'd975, 32'hFFFF_FFFC, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};

        reset = 1'b1;
        start = 1'b0;
        value = '0;
        #3;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_bcd",  64'(bcd),  64'd0);
        check("reset_neg",  64'(neg),  64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Directed values, including sign and magnitude extremes.
        foreach (dir[i]) begin
            issue(dir[i]);
            repeat (34) @(posedge clk);
        end

        // start while busy (busy cycle 10) is ignored.
        issue(32'd777);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        value = 32'd123456;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        check("ignored_start_busy", 64'(busy), 64'd0);
        check("ignored_start_pending", 64'(sb.size()), 64'd0);

        // Asynchronous reset during CONVERT cycle 15 aborts the conversion.
        issue(32'd31337);
        repeat (14) @(posedge clk);
        #2;
        reset = 1'b1;
        void'(sb.pop_back());
        last_bcd = '0;
        last_neg = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_bcd",  64'(bcd),  64'd0);
        check("midreset_neg",  64'(neg),  64'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        issue(32'd42);
        repeat (34) @(posedge clk);

        // Back-to-back: second start raised in the done cycle of the first.
        issue(32'd25);
        repeat (32) @(posedge clk);
        #1;
        check("b2b_done_cycle", 64'(done), 64'd1);
        start = 1'b1;
        value = -32'sd39;
        @(posedge clk);
        #1;
        push(-32'sd39);
        start = 1'b0;
        repeat (34) @(posedge clk);

        // start held high: a conversion every 33 cycles, value wiggling.
        @(posedge clk);
        #1;
        v     = $urandom;
        start = 1'b1;
        value = v;
        for (int i = 0; i < 3 * 33; i++) begin
            @(posedge clk);
            #1;
            if (i % 33 == 0) push(v);
            v     = $urandom;
            value = v;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);

        // Random operands with random gaps, some back-to-back.
        for (int i = 0; i < 25; i++) begin
            v = $urandom;
            if (i % 4 == 1) v = v & 32'h0000_FFFF;
            if (i % 4 == 2) v = v | 32'hFFFF_0000;
            issue(v);
            repeat ($urandom_range(31, 40)) @(posedge clk);
        end

        repeat (40) @(posedge clk);
        #1;
        check("all_results_seen", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bin2bcd_seq
